// File: rtl/gpio_irq_if.sv
// CCX memory interface bundle shared by the core's data-side slaves.
// The requester drives req/wen/strb/wdata/addr; the responder returns
// gnt/rdata/error.
interface scarv_ccx_memif;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, wen, strb, wdata, addr, input gnt, rdata, error);
    modport RSP (input req, wen, strb, wdata, addr, output gnt, rdata, error);
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: GPIO interrupt controller.
// Synchronises raw pin values, detects per-pin level or edge events, latches
// them into sticky PENDING bits and drives one registered interrupt line.
// Register map (addr[3:2]): 0 ENABLE, 1 TYPE, 2 POLARITY, 3 PENDING (W1C).
// Optional macro GPIO_IRQ_DEBOUNCE_EN inserts a per-pin debounce filter of
// DEBOUNCE_CYCLES stable samples between the synchroniser and event logic.
//
// Bus handshake: gnt is always 1, so every cycle with req=1 is a complete
// transfer; reads return combinational rdata in that same cycle (0 when
// req=0), writes commit at the posedge that ends the request cycle.
module gpio_irq #(
    parameter int                           PERIPH_GPIO_NUM = 16,
    parameter logic [PERIPH_GPIO_NUM-1:0]   RESET_ENABLE    = '0,
    parameter logic [PERIPH_GPIO_NUM-1:0]   RESET_TYPE      = '0,
    parameter logic [PERIPH_GPIO_NUM-1:0]   RESET_POLARITY  = '0,
    parameter int                           DEBOUNCE_CYCLES = 4
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    output logic                       g_clk_req,
    input  logic [PERIPH_GPIO_NUM-1:0] gpio_in,
    output logic                       irq,
    scarv_ccx_memif.RSP                memif
);

    localparam int NP = PERIPH_GPIO_NUM - 1;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [NP:0] en_q;
    logic [NP:0] type_q;
    logic [NP:0] pol_q;
    logic [NP:0] pend_q;
    logic [NP:0] sync1;
    logic [NP:0] sync2;
    logic [NP:0] prev;
    logic [1:0]  warm;

    logic [NP:0] f;
    logic [NP:0] f_seed;
    logic [NP:0] rise;
    logic [NP:0] fall;
    logic [NP:0] lvl;
    logic [NP:0] evt;
    logic [NP:0] clr;
    logic        edge_ok;
    logic        wr;
    logic [1:0]  sel;

    // Address bits and byte strobes outside the decoded field are don't-care.
    logic        unused_bits;
    logic [7:0]  unused_db;
    assign unused_bits = ^{memif.addr[31:4], memif.addr[1:0], memif.strb, memif.wdata};
    assign unused_db   = DB_LAST;

    assign g_clk_req   = 1'b1;
    assign memif.gnt   = 1'b1;
    assign memif.error = 1'b0;

    assign wr  = memif.req & memif.wen;
    assign sel = memif.addr[3:2];
    assign clr = (wr && sel == 2'd3) ? memif.wdata[NP:0] : '0;

    // Register read mux; returns 0 whenever no request is presented.
    always_comb begin
        memif.rdata = '0;
        if (memif.req) begin
            case (sel)
                2'd0:    memif.rdata[NP:0] = en_q;
                2'd1:    memif.rdata[NP:0] = type_q;
                2'd2:    memif.rdata[NP:0] = pol_q;
                default: memif.rdata[NP:0] = pend_q;
            endcase
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    logic [7:0]  db_cnt [0:NP];
    logic [NP:0] filt;

    // Debounce: adopt sync2 only after it differs from the filtered value
    // for DEBOUNCE_CYCLES consecutive samples; any return restarts the count.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            filt <= '0;
            for (int i = 0; i <= NP; i++) db_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i <= NP; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        filt[i]   <= sync2[i];
                        db_cnt[i] <= 8'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= 8'd0;
                end
            end
        end
    end

    assign f      = filt;
    assign f_seed = filt;
`else
    assign f      = sync2;
    // While warming up, prev is seeded from sync1 so it already equals sync2
    // when edge detection opens; pins held active through reset give no edge.
    assign f_seed = sync1;
`endif

    assign edge_ok = (warm == 2'd2);
    assign rise    = f & ~prev & {PERIPH_GPIO_NUM{edge_ok}};
    assign fall    = ~f & prev & {PERIPH_GPIO_NUM{edge_ok}};
    assign lvl     = ~(f ^ pol_q);
    assign evt     = (type_q & ((pol_q & rise) | (~pol_q & fall))) | (~type_q & lvl);

    // Input synchroniser, edge history and warm-up counter.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            warm  <= 2'd0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            prev  <= edge_ok ? f : f_seed;
            if (warm != 2'd2) warm <= warm + 2'd1;
        end
    end

    // Config registers, sticky PENDING (set wins over W1C) and registered irq.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            en_q   <= RESET_ENABLE;
            type_q <= RESET_TYPE;
            pol_q  <= RESET_POLARITY;
            pend_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && sel == 2'd0) en_q   <= memif.wdata[NP:0];
            if (wr && sel == 2'd1) type_q <= memif.wdata[NP:0];
            if (wr && sel == 2'd2) pol_q  <= memif.wdata[NP:0];
            pend_q <= (pend_q & ~clr) | (evt & en_q);
            irq    <= |(pend_q & en_q);
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: register reset values, edge/level detection
// latency, W1C behaviour, set/clear collision, enable masking and reset.
module tb_gpio_irq;
    localparam int NPIN = 16;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            g_clk_req;
    logic            irq;
    logic [NPIN-1:0] gpio_in;
    logic [31:0]     v;
    int              total = 0;
    int              bad = 0;

    scarv_ccx_memif memif();

    gpio_irq #(.PERIPH_GPIO_NUM(NPIN), .DEBOUNCE_CYCLES(4)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .g_clk_req (g_clk_req),
        .gpio_in   (gpio_in),
        .irq       (irq),
        .memif     (memif)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a posedge.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        memif.req   = 1'b1;
        memif.wen   = 1'b1;
        memif.addr  = addr;
        memif.wdata = data;
        tick();
        memif.req   = 1'b0;
        memif.wen   = 1'b0;
    endtask

    // Combinational read inside the current cycle; no clock edge consumed.
    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        memif.req  = 1'b1;
        memif.wen  = 1'b0;
        memif.addr = addr;
        #1;
        data = memif.rdata;
        memif.req  = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        memif.req   = 1'b0;
        memif.wen   = 1'b0;
        memif.strb  = 4'hf;
        memif.addr  = '0;
        memif.wdata = '0;
        gpio_in     = 16'hffff;

        // Reset with all pins high.
        idle(4);
        check("irq_in_reset", {31'd0, irq}, 32'd0);
        g_resetn = 1'b1;
        idle(5 + EXTRA);
        chk_reg("rst_enable", 32'h0, 32'h0);
        chk_reg("rst_type", 32'h4, 32'h0);
        chk_reg("rst_polarity", 32'h8, 32'h0);
        chk_reg("rst_pending", 32'hc, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("clk_req", {31'd0, g_clk_req}, 32'd1);
        check("gnt", {31'd0, memif.gnt}, 32'd1);
        check("error", {31'd0, memif.error}, 32'd0);

        // Steady high pins with rising-edge config: no events.
        bus_wr(32'h0, 32'hffff);
        bus_wr(32'h4, 32'hffff);
        bus_wr(32'h8, 32'hffff);
        idle(3);
        chk_reg("steady_no_edge", 32'hc, 32'h0);
        check("steady_irq", {31'd0, irq}, 32'd0);
        bus_wr(32'h0, 32'h0);

        // Rising edge on pin 0 with exact latency.
        gpio_in = 16'h0000;
        idle(4 + EXTRA);
        bus_wr(32'h0, 32'h1);
        bus_wr(32'h4, 32'h1);
        bus_wr(32'h8, 32'h1);
        bus_wr(32'hc, 32'hffff);
        gpio_in = 16'h0001;
        tick();                 // N: sync1 captures
        idle(1 + EXTRA);        // N+1(+debounce)
        chk_reg("rise_pend_early", 32'hc, 32'h0);
        check("rise_irq_early", {31'd0, irq}, 32'd0);
        tick();                 // N+2
        chk_reg("rise_pend_set", 32'hc, 32'h1);
        check("rise_irq_lag", {31'd0, irq}, 32'd0);
        tick();                 // N+3
        check("rise_irq_set", {31'd0, irq}, 32'd1);
        bus_wr(32'hc, 32'h1);
        chk_reg("w1c_clear", 32'hc, 32'h0);
        check("w1c_irq_lag", {31'd0, irq}, 32'd1);
        tick();
        check("w1c_irq_low", {31'd0, irq}, 32'd0);

        // Level persistence on pin 4.
        bus_wr(32'h0, 32'h10);
        bus_wr(32'h4, 32'h0);
        bus_wr(32'h8, 32'h10);
        gpio_in = 16'h0011;
        idle(4 + EXTRA);
        chk_reg("lvl_pend", 32'hc, 32'h10);
        check("lvl_irq", {31'd0, irq}, 32'd1);
        bus_wr(32'hc, 32'h10);
        chk_reg("lvl_reassert", 32'hc, 32'h10);
        gpio_in = 16'h0001;
        idle(3 + EXTRA);
        bus_wr(32'hc, 32'h10);
        chk_reg("lvl_gone_clear", 32'hc, 32'h0);
        tick();
        check("lvl_gone_irq", {31'd0, irq}, 32'd0);

        // Falling edge on pin 3 colliding with a W1C of the same bit.
        bus_wr(32'h0, 32'h0);
        bus_wr(32'h4, 32'h8);
        bus_wr(32'h8, 32'h0);
        gpio_in = 16'h0008;
        idle(4 + EXTRA);
        bus_wr(32'hc, 32'hffff);
        bus_wr(32'h0, 32'h8);
        chk_reg("coll_pre", 32'hc, 32'h0);
        gpio_in = 16'h0000;
        tick();                 // N
        idle(1 + EXTRA);        // N+1(+debounce)
        bus_wr(32'hc, 32'h8);   // commits at N+2(+debounce)
        chk_reg("coll_set_wins", 32'hc, 32'h8);
        tick();
        chk_reg("coll_sticky", 32'hc, 32'h8);
        bus_wr(32'hc, 32'h8);
        chk_reg("coll_clear", 32'hc, 32'h0);

        // Enable masking on pin 7.
        bus_wr(32'h0, 32'h0);
        bus_wr(32'h4, 32'h80);
        bus_wr(32'h8, 32'h80);
        idle(4 + EXTRA);
        bus_wr(32'hc, 32'hffff);
        gpio_in = 16'h0080;
        idle(4 + EXTRA);
        chk_reg("mask_no_set", 32'hc, 32'h0);
        bus_wr(32'h0, 32'h80);
        gpio_in = 16'h0000;
        idle(4 + EXTRA);
        gpio_in = 16'h0080;
        idle(4 + EXTRA);
        chk_reg("mask_set", 32'hc, 32'h80);
        check("mask_irq", {31'd0, irq}, 32'd1);
        bus_wr(32'h0, 32'h0);
        chk_reg("dis_keeps_pend", 32'hc, 32'h80);
        tick();
        check("dis_irq_low", {31'd0, irq}, 32'd0);
        bus_wr(32'h4, 32'h0);
        bus_wr(32'h8, 32'h0);
        chk_reg("cfg_keeps_pend", 32'hc, 32'h80);

        // Bus corner cases.
        memif.req  = 1'b0;
        memif.addr = 32'hc;
        #1;
        check("rdata_idle_zero", memif.rdata, 32'h0);
        chk_reg("addr_low_ignored", 32'hf, 32'h80);
        bus_wr(32'h0, 32'hffffffff);
        chk_reg("upper_bits_zero", 32'h0, 32'h0000ffff);
        tick();
        check("reenable_irq", {31'd0, irq}, 32'd1);

        // Reset mid-operation.
        g_resetn = 1'b0;
        idle(2);
        g_resetn = 1'b1;
        check("midrst_irq", {31'd0, irq}, 32'd0);
        chk_reg("midrst_pend", 32'hc, 32'h0);
        chk_reg("midrst_enable", 32'h0, 32'h0);
        tick();
        check("midrst_irq_after", {31'd0, irq}, 32'd0);

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // Debounce: short glitch filtered, wide pulse yields one rising event.
        gpio_in = 16'h0000;
        bus_wr(32'h0, 32'h2);
        bus_wr(32'h4, 32'h2);
        bus_wr(32'h8, 32'h2);
        idle(12);
        bus_wr(32'hc, 32'hffff);
        chk_reg("db_pre", 32'hc, 32'h0);
        gpio_in = 16'h0002;
        idle(3);
        gpio_in = 16'h0000;
        idle(10);
        chk_reg("db_glitch", 32'hc, 32'h0);
        gpio_in = 16'h0002;
        idle(6);
        chk_reg("db_pulse_early", 32'hc, 32'h0);
        gpio_in = 16'h0000;
        tick();
        chk_reg("db_pulse_set", 32'hc, 32'h2);
        idle(10);
        bus_wr(32'hc, 32'h2);
        chk_reg("db_single_event", 32'hc, 32'h0);
`endif

        v = 32'(bad);
        $display("test done: total=%0d bad=%0d", total, v);
        $finish;
    end

endmodule
